odd_parity_serializer: RTL and testbench

//   Parallel-to-serial framer that produces the single-bit stream w consumed
//   by the downstream sequence-detector FSM (input w, output q).

---
 rtl/odd_parity_serializer.sv | 112 +++++++++++
 tb/tb_odd_parity_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/odd_parity_serializer.sv
// Parallel-to-serial framer: shifts a DATA_W-bit word out on w, one bit per clock,
// then appends an odd-parity bit (optionally inverted for error injection).
module odd_parity_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              inject_err,
  output logic              din_ready,
  output logic              w,
  output logic              w_valid,
  output logic              frame_start,
  output logic              par_bit
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_w;
  logic              r_wValid;
  logic              r_frameStart;
  logic              r_parBit;

  logic              w_load;
  logic              w_lastBit;
  logic              w_loadHead;
  logic              w_nextHead;
  logic [DATA_W-1:0] w_shiftNext;

  assign din_ready = (r_state == IDLE) || (r_state == PARITY);
  assign w_load    = din_valid && din_ready;
  assign w_lastBit = (r_cnt == CNT_W'(DATA_W - 1));

  // r_shift always keeps the bit currently on w at its head position.
  assign w_shiftNext = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0}
                                 : {1'b0, r_shift[DATA_W-1:1]};
  assign w_loadHead  = MSB_FIRST ? din[DATA_W-1]         : din[0];
  assign w_nextHead  = MSB_FIRST ? w_shiftNext[DATA_W-1] : w_shiftNext[0];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_cnt        <= '0;
      r_w          <= 1'b0;
      r_wValid     <= 1'b0;
      r_frameStart <= 1'b0;
      r_parBit     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, PARITY: begin
          if (w_load) begin
            r_state      <= DATA;
            r_shift      <= din;
            r_par        <= (~^din) ^ inject_err;
            r_cnt        <= '0;
            r_w          <= w_loadHead;
            r_wValid     <= 1'b1;
            r_frameStart <= 1'b1;
            r_parBit     <= 1'b0;
          end else begin
            r_state      <= IDLE;
            r_w          <= 1'b0;
            r_wValid     <= 1'b0;
            r_frameStart <= 1'b0;
            r_parBit     <= 1'b0;
          end
        end
        DATA: begin
          r_frameStart <= 1'b0;
          r_wValid     <= 1'b1;
          if (w_lastBit) begin
            r_state  <= PARITY;
            r_w      <= r_par;
            r_parBit <= 1'b1;
          end else begin
            r_shift  <= w_shiftNext;
            r_cnt    <= r_cnt + CNT_W'(1);
            r_w      <= w_nextHead;
            r_parBit <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_w          <= 1'b0;
          r_wValid     <= 1'b0;
          r_frameStart <= 1'b0;
          r_parBit     <= 1'b0;
        end
      endcase
    end
  end

  assign w           = r_w;
  assign w_valid     = r_wValid;
  assign frame_start = r_frameStart;
  assign par_bit     = r_parBit;

endmodule

// File: tb/tb_odd_parity_serializer.sv
// Bench for odd_parity_serializer: queue-based frame model checked every cycle,
// a word/parity scoreboard, and directed frames with hand-computed streams.
module tb_odd_parity_serializer;

  localparam int DATA_W    = 8;
  localparam bit MSB_FIRST = 1'b1;

  logic              clk = 1'b0;
  logic              arstn = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              inject_err = 1'b0;
  logic              din_ready;
  logic              w;
  logic              w_valid;
  logic              frame_start;
  logic              par_bit;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic bitVal;
    logic fs;
    logic par;
  } ent_t;

  ent_t              expQ[$];
  ent_t              cur;
  logic              curValid = 1'b0;
  logic [DATA_W:0]   refQ[$];
  logic [DATA_W-1:0] scbWord = '0;
  logic              scbActive = 1'b0;

  odd_parity_serializer #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) dut (
    .clk         (clk),
    .arstn       (arstn),
    .din         (din),
    .din_valid   (din_valid),
    .inject_err  (inject_err),
    .din_ready   (din_ready),
    .w           (w),
    .w_valid     (w_valid),
    .frame_start (frame_start),
    .par_bit     (par_bit)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] word, input logic valid, input logic inj);
    din        = word;
    din_valid  = valid;
    inject_err = inj;
  endtask

  // A frame is the data bits in transmit order followed by a bit making the total count of ones odd.
  task automatic modelLoad(input logic [DATA_W-1:0] word, input logic inj);
    ent_t e;
    for (int i = 0; i < DATA_W; i++) begin
      e.bitVal = MSB_FIRST ? word[DATA_W-1-i] : word[i];
      e.fs     = (i == 0);
      e.par    = 1'b0;
      expQ.push_back(e);
    end
    e.bitVal = (($countones(word) % 2) == 0) ^ inj;
    e.fs     = 1'b0;
    e.par    = 1'b1;
    expQ.push_back(e);
    refQ.push_back({inj, word});
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge arstn);
      if (!arstn) begin
        expQ.delete();
        refQ.delete();
        curValid  = 1'b0;
        scbActive = 1'b0;
      end else begin
        if (din_valid && expQ.size() == 0) modelLoad(din, inject_err);
        if (expQ.size() > 0) begin
          cur      = expQ.pop_front();
          curValid = 1'b1;
        end else begin
          curValid = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [4:0]      expVec;
    logic [4:0]      actVec;
    logic [DATA_W:0] refEnt;
    logic            expPar;
    forever begin
      @(negedge clk);
      expVec = {curValid & cur.bitVal, curValid, curValid & cur.fs, curValid & cur.par, expQ.size() == 0};
      actVec = {w, w_valid, frame_start, par_bit, din_ready};
      checkOutput("cycle_outputs", 32'(actVec), 32'(expVec));
      if (w_valid) begin
        if (frame_start) begin
          scbActive = 1'b1;
          scbWord   = '0;
        end
        if (par_bit) begin
          checkOutput("scb_frame_open", 32'(scbActive && refQ.size() != 0), 32'd1);
          if (scbActive && refQ.size() != 0) begin
            refEnt = refQ.pop_front();
            expPar = (($countones(refEnt[DATA_W-1:0]) % 2) == 0) ^ refEnt[DATA_W];
            checkOutput("scb_word", 32'(scbWord), 32'(refEnt[DATA_W-1:0]));
            checkOutput("scb_parity", 32'(w), 32'(expPar));
          end
          scbActive = 1'b0;
        end else if (MSB_FIRST) begin
          scbWord = {scbWord[DATA_W-2:0], w};
        end else begin
          scbWord = {w, scbWord[DATA_W-1:1]};
        end
      end
    end
  end

  task automatic captureFrame(input logic [DATA_W-1:0] word, input logic inj,
                              output logic [8:0] bits, output logic [8:0] fsSeq,
                              output logic [8:0] parSeq, output logic [8:0] vSeq);
    bits = '0; fsSeq = '0; parSeq = '0; vSeq = '0;
    @(negedge clk);
    applyStimulus(word, 1'b1, inj);
    @(negedge clk);
    applyStimulus(~word, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      bits   = {bits[7:0], w};
      fsSeq  = {fsSeq[7:0], frame_start};
      parSeq = {parSeq[7:0], par_bit};
      vSeq   = {vSeq[7:0], w_valid};
    end
  endtask

  initial begin
    logic [8:0]  bits, fsSeq, parSeq, vSeq;
    logic [17:0] cap18, v18, r18;

    applyStimulus(8'hFF, 1'b1, 1'b0);
    arstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_w", 32'(w), 32'd0);
    checkOutput("reset_w_valid", 32'(w_valid), 32'd0);
    arstn = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("reset_din_ready", 32'(din_ready), 32'd1);

    captureFrame(8'hA5, 1'b0, bits, fsSeq, parSeq, vSeq);
    checkOutput("a5_stream", 32'(bits), 32'h14B);
    checkOutput("a5_frame_start", 32'(fsSeq), 32'h100);
    checkOutput("a5_par_bit", 32'(parSeq), 32'h001);
    checkOutput("a5_valid", 32'(vSeq), 32'h1FF);
    @(negedge clk);
    checkOutput("a5_idle_after", 32'(w_valid), 32'd0);

    captureFrame(8'hFF, 1'b0, bits, fsSeq, parSeq, vSeq);
    checkOutput("ff_stream", 32'(bits), 32'h1FF);
    captureFrame(8'h07, 1'b0, bits, fsSeq, parSeq, vSeq);
    checkOutput("07_stream", 32'(bits), 32'h00E);

    // Back-to-back: valid held across the first frame's parity cycle.
    cap18 = '0; v18 = '0; r18 = '0;
    @(negedge clk);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      cap18 = {cap18[16:0], w};
      v18   = {v18[16:0], w_valid};
      r18   = {r18[16:0], din_ready};
      if (i == 0) din = 8'h01;
      if (i == 9) din_valid = 1'b0;
    end
    checkOutput("b2b_stream", 32'(cap18), 32'h3E02);
    checkOutput("b2b_valid", 32'(v18), 32'h3FFFF);
    checkOutput("b2b_ready", 32'(r18), 32'h201);

    captureFrame(8'hA5, 1'b1, bits, fsSeq, parSeq, vSeq);
    checkOutput("inj_stream", 32'(bits), 32'h14A);
    captureFrame(8'hA5, 1'b0, bits, fsSeq, parSeq, vSeq);
    checkOutput("post_inj_stream", 32'(bits), 32'h14B);

    // Abort mid-frame on data bit 4 of 0x3C, then a fresh frame.
    @(negedge clk);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("abort_bit4_before", 32'(w), 32'd1);
    #2 arstn = 1'b0;
    #1;
    checkOutput("abort_w", 32'(w), 32'd0);
    checkOutput("abort_w_valid", 32'(w_valid), 32'd0);
    checkOutput("abort_din_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    arstn = 1'b1;
    captureFrame(8'hC3, 1'b0, bits, fsSeq, parSeq, vSeq);
    checkOutput("post_abort_stream", 32'(bits), 32'h187);
    checkOutput("post_abort_valid", 32'(vSeq), 32'h1FF);
    checkOutput("post_abort_fs", 32'(fsSeq), 32'h100);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
